bus_arbiter_ctrl: RTL and testbench
===================================

BUS_ARBITER_CTRL -- requirements
Module: bus_arbiter_ctrl

Interface
REQ-001 The block SHALL have one parameter: MAXHOLD, default 8, meaning the maximum number of consecutive grant cycles while the other master is requesting (legal range 2..15).
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0  input  1  master 0 requests the shared 3-bit bus.
REQ-005 req1  input  1  master 1 requests the shared 3-bit bus.
REQ-006 flowvalve0  output  1  enable to master 0's 3-bit transceiver.
REQ-007 conflictstatus0  output  1  high = no conflict for master 0 (req1 was low at the last edge).
REQ-008 prioritystatus0  output  1  high = master 0 currently holds priority.
REQ-009 flowvalve1, conflictstatus1, prioritystatus1  output  1 each  same meanings for master 1, mirrored.
REQ-010 busy  output  1  high while not in IDLE.
REQ-011 grantid  output  1  index of the current or most recent granted master.
REQ-012 preempt  output  1  one-cycle pulse when a grant is forcibly ended by MAXHOLD.

Function
REQ-013 All outputs SHALL be registered; no combinational path from req0/req1 to any output.
REQ-014 FSM states SHALL be IDLE, GRANT0, GRANT1 and TURN; outputs SHALL be Moore functions of the state register, except conflictstatusN, which is registered from the other master's req.
REQ-015 In GRANTn, flowvalven=1 and prioritystatusn=1; in every other state, both flowvalve and both priority outputs SHALL be 0.
REQ-016 conflictstatus0 SHALL equal ~req1 sampled at the previous edge; conflictstatus1 SHALL equal ~req0 sampled at the previous edge.
REQ-017 A 1-bit round-robin pointer rrptr SHALL select the preferred master on a simultaneous request; rrptr SHALL be 0 (master 0 preferred) after reset.
REQ-018 In IDLE or TURN, with exactly one req high, the next state SHALL be that master's GRANT state.
REQ-019 In IDLE or TURN, with both req high, the next state SHALL be GRANT(rrptr).
REQ-020 In IDLE or TURN, with no req high, the next state SHALL be IDLE.
REQ-021 On entry to GRANTn, holdcount SHALL be cleared to 0 and grantid SHALL be set to n.
REQ-022 While in GRANTn, holdcount SHALL increment each cycle and saturate at MAXHOLD-1.
REQ-023 In GRANTn, if reqn is low, the next state SHALL be TURN and rrptr SHALL become ~n.
REQ-024 In GRANTn, if reqn and the other req are both high and holdcount==MAXHOLD-1, the next state SHALL be TURN, rrptr SHALL become ~n, and preempt SHALL pulse high for the first TURN cycle.
REQ-025 With no contention, a GRANT SHALL be held indefinitely while reqn stays high.
REQ-026 A contended grant SHALL last exactly MAXHOLD cycles when contention exists from the grant's first cycle.
REQ-027 TURN SHALL last exactly one cycle with both flowvalves low, guaranteeing a bus-free cycle between owners.
REQ-028 Grant latency SHALL be 1 cycle from IDLE: req sampled high at edge k gives flowvalve high after edge k.
REQ-029 busy SHALL be 1 in GRANT0, GRANT1 and TURN, and 0 in IDLE.
REQ-030 grantid SHALL hold its value through TURN and IDLE.
REQ-031 flowvalve0 and flowvalve1 SHALL never be high in the same cycle.

Reset
REQ-032 reset high at an edge SHALL force state=IDLE, rrptr=0, holdcount=0, and all outputs to 0, regardless of state, including mid-grant.
REQ-033 reset SHALL take priority over all transitions; the first decision SHALL occur at the first edge with reset low.

Verification
REQ-034 Reset with req0=req1=1 held; release reset -> edge 1: GRANT0, flowvalve0=1, prioritystatus0=1, conflictstatus0=0, busy=1, grantid=0.
REQ-035 MAXHOLD=8, both req held high -> flowvalve0 high exactly 8 cycles, then 1 TURN cycle (both flowvalves 0, preempt=1), then flowvalve1 high for 8 cycles; pattern repeats.
REQ-036 req1 only, for 20 cycles, then drop -> flowvalve1 high 20 cycles, conflictstatus1=1 throughout, then TURN, then IDLE with busy=0 and grantid=1.
REQ-037 In GRANT1, assert reset for 1 cycle -> next cycle all outputs 0 and IDLE; with req0=req1=1, the following grant goes to master 0 (rrptr=0).
REQ-038 In GRANT0, req0 drops while req1 rises on the same edge -> TURN for 1 cycle, then GRANT1, with no preempt pulse.
REQ-039 Random req stimulus for 10k cycles -> flowvalve0&flowvalve1 never 1, every owner change passes through a TURN cycle, and no contended grant exceeds MAXHOLD cycles.

Source files
------------

// File: rtl/bus_arbiter_ctrl.sv
// bus_arbiter_ctrl
//   Two-master arbiter for a shared 3-bit bus. Grants are round-robin on
//   simultaneous requests, a contended grant is cut off after MAXHOLD
//   cycles, and every change of owner passes through one bus-free TURN cycle.
//
// Parameters
//   MAXHOLD          max consecutive grant cycles while the other master
//                    is requesting (2..15)
// Ports
//   clock            rising-edge clock
//   reset            synchronous, active-high reset
//   req0, req1       bus requests from master 0 / master 1
//   flowvalve0/1     transceiver enable for the owning master
//   conflictstatus0  ~req1 as sampled at the previous edge
//   conflictstatus1  ~req0 as sampled at the previous edge
//   prioritystatus0/1 high while that master holds the grant
//   busy             high in any state other than IDLE
//   grantid          index of the current or most recent owner
//   preempt          one-cycle pulse in the TURN cycle after a forced release
module bus_arbiter_ctrl #(
    parameter int unsigned MAXHOLD = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    output logic flowvalve0,
    output logic conflictstatus0,
    output logic prioritystatus0,
    output logic flowvalve1,
    output logic conflictstatus1,
    output logic prioritystatus1,
    output logic busy,
    output logic grantid,
    output logic preempt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        TURN   = 2'd3
    } state_t;

    localparam logic [3:0] HOLDLAST = 4'(MAXHOLD - 1);

    state_t     state_q, state_d;
    logic       rrptr_q, rrptr_d;
    logic [3:0] holdcount_q, holdcount_d;
    logic       preempt_d;

    always_comb begin
        state_d   = state_q;
        rrptr_d   = rrptr_q;
        preempt_d = 1'b0;

        unique case (state_q)
            IDLE, TURN: begin
                if (req0 && req1)
                    state_d = rrptr_q ? GRANT1 : GRANT0;
                else if (req0)
                    state_d = GRANT0;
                else if (req1)
                    state_d = GRANT1;
                else
                    state_d = IDLE;
            end
            GRANT0: begin
                if (!req0) begin
                    state_d = TURN;
                    rrptr_d = 1'b1;
                end else if (req1 && holdcount_q == HOLDLAST) begin
                    state_d   = TURN;
                    rrptr_d   = 1'b1;
                    preempt_d = 1'b1;
                end
            end
            GRANT1: begin
                if (!req1) begin
                    state_d = TURN;
                    rrptr_d = 1'b0;
                end else if (req0 && holdcount_q == HOLDLAST) begin
                    state_d   = TURN;
                    rrptr_d   = 1'b0;
                    preempt_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Owners never move directly between grants, so staying in the same
        // GRANT state means continuing the grant; any other path is an entry.
        holdcount_d = '0;
        if ((state_d == GRANT0 || state_d == GRANT1) && state_d == state_q)
            holdcount_d = (holdcount_q == HOLDLAST) ? holdcount_q : holdcount_q + 4'd1;
    end

    // Outputs are flopped from the next-state decode so they line up with
    // the state register while staying free of any req-to-output path.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            rrptr_q         <= 1'b0;
            holdcount_q     <= '0;
            flowvalve0      <= 1'b0;
            flowvalve1      <= 1'b0;
            prioritystatus0 <= 1'b0;
            prioritystatus1 <= 1'b0;
            conflictstatus0 <= 1'b0;
            conflictstatus1 <= 1'b0;
            busy            <= 1'b0;
            grantid         <= 1'b0;
            preempt         <= 1'b0;
        end else begin
            state_q         <= state_d;
            rrptr_q         <= rrptr_d;
            holdcount_q     <= holdcount_d;
            flowvalve0      <= (state_d == GRANT0);
            flowvalve1      <= (state_d == GRANT1);
            prioritystatus0 <= (state_d == GRANT0);
            prioritystatus1 <= (state_d == GRANT1);
            conflictstatus0 <= ~req1;
            conflictstatus1 <= ~req0;
            busy            <= (state_d != IDLE);
            preempt         <= preempt_d;
            if (state_d == GRANT0)
                grantid <= 1'b0;
            else if (state_d == GRANT1)
                grantid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_ctrl.sv
// tb_bus_arbiter_ctrl
//   Self-checking bench for bus_arbiter_ctrl. A cycle-level reference model
//   tracks the owner as an integer (-1 idle, 0/1 granted, 2 handover) and the
//   number of cycles the current grant has lasted.
module tb_bus_arbiter_ctrl;

    localparam int MH = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic req0  = 1'b0;
    logic req1  = 1'b0;
    logic flowvalve0, conflictstatus0, prioritystatus0;
    logic flowvalve1, conflictstatus1, prioritystatus1;
    logic busy, grantid, preempt;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int m_owner = -1;
    int m_held  = 0;
    int m_rr    = 0;
    int m_gid   = 0;
    bit m_pre   = 1'b0;
    bit m_cs0   = 1'b0;
    bit m_cs1   = 1'b0;

    always #5 clock = ~clock;

    bus_arbiter_ctrl #(.MAXHOLD(MH)) dut (
        .clock           (clock),
        .reset           (reset),
        .req0            (req0),
        .req1            (req1),
        .flowvalve0      (flowvalve0),
        .conflictstatus0 (conflictstatus0),
        .prioritystatus0 (prioritystatus0),
        .flowvalve1      (flowvalve1),
        .conflictstatus1 (conflictstatus1),
        .prioritystatus1 (prioritystatus1),
        .busy            (busy),
        .grantid         (grantid),
        .preempt         (preempt)
    );

    function automatic void model_update(input bit r, input bit a, input bit b);
        bit rq[2];
        int pick;
        rq[0] = a;
        rq[1] = b;
        pick  = -1;
        if (r) begin
            m_owner = -1; m_held = 0; m_rr = 0; m_gid = 0;
            m_pre = 1'b0; m_cs0 = 1'b0; m_cs1 = 1'b0;
            return;
        end
        m_cs0 = !b;
        m_cs1 = !a;
        m_pre = 1'b0;
        if (m_owner == 0 || m_owner == 1) begin
            if (!rq[m_owner] || (rq[1 - m_owner] && m_held >= MH)) begin
                m_pre   = rq[m_owner];
                m_rr    = 1 - m_owner;
                m_owner = 2;
            end else begin
                m_held++;
            end
        end else begin
            if (a && b) pick = m_rr;
            else if (a) pick = 0;
            else if (b) pick = 1;
            if (pick < 0) m_owner = -1;
            else begin
                m_owner = pick;
                m_held  = 1;
                m_gid   = pick;
            end
        end
    endfunction

    function automatic logic [8:0] exp_vec();
        return {m_owner == 0, m_cs0, m_owner == 0,
                m_owner == 1, m_cs1, m_owner == 1,
                m_owner != -1, m_gid[0], m_pre};
    endfunction

    function automatic logic [8:0] dut_vec();
        return {flowvalve0, conflictstatus0, prioritystatus0,
                flowvalve1, conflictstatus1, prioritystatus1,
                busy, grantid, preempt};
    endfunction

    // Drive inputs on the falling edge, let the rising edge act, then look
    // at outputs 1 time unit later.
    task automatic step(input bit r, input bit a, input bit b);
        @(negedge clock);
        reset = r; req0 = a; req1 = b;
        @(posedge clock);
        model_update(r, a, b);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1);
            n_cmp++;
            if (dut_vec() !== 9'b0) begin
                n_bad++;
                $display("FAIL reset_outputs cyc%0d: got %b want %b", i, dut_vec(), 9'b0);
            end
        end
        // release with both requests held: master 0 wins first
        step(1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (dut_vec() !== 9'b1_0_1_0_0_0_1_0_0) begin
            n_bad++;
            $display("FAIL reset_release: got %b want %b", dut_vec(), 9'b101000100);
        end
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL reset_release_model: got %b want %b", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_maxhold();
        int fv0_cnt = 0;
        int fv1_cnt = 0;
        bit turn_pre = 1'b0;
        bit turn_free = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 2 * MH + 3; i++) begin
            step(1'b0, 1'b1, 1'b1);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL maxhold cyc%0d: got %b want %b", i, dut_vec(), exp_vec());
            end
            if (i <= MH + 1 && flowvalve0) fv0_cnt++;
            if (i == MH + 1) begin
                turn_pre  = preempt;
                turn_free = !flowvalve0 && !flowvalve1;
            end
            if (i >= MH + 2 && i <= 2 * MH + 1 && flowvalve1) fv1_cnt++;
        end
        n_cmp++;
        if (fv0_cnt !== MH) begin
            n_bad++;
            $display("FAIL maxhold_len0: got %0d want %0d", fv0_cnt, MH);
        end
        n_cmp++;
        if (fv1_cnt !== MH) begin
            n_bad++;
            $display("FAIL maxhold_len1: got %0d want %0d", fv1_cnt, MH);
        end
        n_cmp++;
        if ({turn_pre, turn_free} !== 2'b11) begin
            n_bad++;
            $display("FAIL maxhold_turn: got pre=%b free=%b want 1 1", turn_pre, turn_free);
        end
        n_cmp++;
        if (flowvalve0 !== 1'b1) begin
            n_bad++;
            $display("FAIL maxhold_repeat: got fv0=%b want 1", flowvalve0);
        end
    endtask

    task automatic test_single_req();
        int fv1_cnt = 0;
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b1);
            if (flowvalve1 && conflictstatus1) fv1_cnt++;
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL single_req cyc%0d: got %b want %b", i, dut_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (fv1_cnt !== 20) begin
            n_bad++;
            $display("FAIL single_req_len: got %0d want 20", fv1_cnt);
        end
        step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({flowvalve0, flowvalve1, busy, grantid, preempt} !== 5'b00110) begin
            n_bad++;
            $display("FAIL single_req_turn: got %b want %b",
                     {flowvalve0, flowvalve1, busy, grantid, preempt}, 5'b00110);
        end
        step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({busy, grantid} !== 2'b01 || dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL single_req_idle: got %b want %b", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_midgrant();
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (flowvalve1 !== 1'b1) begin
            n_bad++;
            $display("FAIL midgrant_setup: got fv1=%b want 1", flowvalve1);
        end
        step(1'b1, 1'b1, 1'b1);
        n_cmp++;
        if (dut_vec() !== 9'b0) begin
            n_bad++;
            $display("FAIL midgrant_reset: got %b want %b", dut_vec(), 9'b0);
        end
        step(1'b0, 1'b1, 1'b1);
        n_cmp++;
        if ({flowvalve0, flowvalve1, grantid} !== 3'b100 || dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL midgrant_regrant: got %b want %b", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_handoff();
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        n_cmp++;
        if ({flowvalve0, flowvalve1, busy, preempt} !== 4'b0010) begin
            n_bad++;
            $display("FAIL handoff_turn: got %b want %b",
                     {flowvalve0, flowvalve1, busy, preempt}, 4'b0010);
        end
        step(1'b0, 1'b0, 1'b1);
        n_cmp++;
        if ({flowvalve1, grantid, preempt} !== 3'b110 || dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL handoff_grant1: got %b want %b", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        bit a = 1'b0;
        bit b = 1'b0;
        bit r;
        bit pfv0 = 1'b0;
        bit pfv1 = 1'b0;
        int s0 = 0;
        int s1 = 0;
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 9) < 2) a = !a;
            if ($urandom_range(0, 9) < 2) b = !b;
            r = ($urandom_range(0, 499) == 0);
            step(r, a, b);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL random_model cyc%0d: got %b want %b", i, dut_vec(), exp_vec());
            end
            n_cmp++;
            if (flowvalve0 && flowvalve1) begin
                n_bad++;
                $display("FAIL random_overlap cyc%0d: got fv=11 want not both", i);
            end
            n_cmp++;
            if ((flowvalve0 && pfv1) || (flowvalve1 && pfv0)) begin
                n_bad++;
                $display("FAIL random_noturn cyc%0d: got prev=%b%b now=%b%b want bus-free gap",
                         i, pfv0, pfv1, flowvalve0, flowvalve1);
            end
            // consecutive granted cycles during which the other master was asking
            s0 = (pfv0 && b && !r) ? s0 + 1 : 0;
            s1 = (pfv1 && a && !r) ? s1 + 1 : 0;
            n_cmp++;
            if (s0 > MH || s1 > MH) begin
                n_bad++;
                $display("FAIL random_holdlimit cyc%0d: got %0d/%0d want <= %0d", i, s0, s1, MH);
            end
            pfv0 = flowvalve0;
            pfv1 = flowvalve1;
        end
    endtask

    initial begin
        test_reset();
        test_maxhold();
        test_single_req();
        test_reset_midgrant();
        test_handoff();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
